// File: rtl/m_rx_frame_check.sv
// Receive-side frame error checker.
// Follows a received frame byte by byte, feeds header and payload bytes to the
// CRC engine, captures marker/status/length/CRC fields and, one cycle after
// the frame ends, publishes a registered error vector with a one-cycle strobe.
// Saturating frame and error counters are kept alongside.
//
// Handshake: d_vld is a one-cycle strobe qualifying d; there is no ready, so
// every strobed byte is consumed in the cycle it is presented (bytes strobed
// during the single REPORT cycle are ignored). rx_errs_vld is a one-cycle
// strobe; rx_errs holds its value until the next strobe.
module m_rx_frame_check #(
  parameter logic [7:0] MARKER    = 8'h5A,
  parameter int         MRK_POS   = 0,
  parameter int         STS_POS   = 1,
  parameter int         LEN_POS   = 3,
  parameter int         HDR_LEN   = 4,
  parameter int         CRC_BYTES = 2,
  parameter int         MAX_LEN   = 255,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       d,
  input  logic             d_vld,
  input  logic             pb_err,
  input  logic [15:0]      crc_calc,
  input  logic             frame_end,
  input  logic             cnt_clr,
  output logic             crc_en,
  output logic             crc_rst,
  output logic [6:0]       rx_errs,
  output logic             rx_errs_vld,
  output logic             service_req,
  output logic             sd_busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RX     = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [9:0]  MRK_IDX  = 10'(MRK_POS);
  localparam logic [9:0]  STS_IDX  = 10'(STS_POS);
  localparam logic [9:0]  LEN_IDX  = 10'(LEN_POS);
  localparam logic [9:0]  HDR_L    = 10'(HDR_LEN);
  localparam logic [9:0]  CRC_L    = 10'(CRC_BYTES);
  localparam logic [9:0]  MAX_N    = 10'(MAX_LEN);
  localparam logic [9:0]  IDX_MAX  = 10'd1023;
  localparam logic [15:0] CRC_MASK = (CRC_BYTES == 1) ? 16'h00FF : 16'hFFFF;

  state_t           state_q, state_d;
  logic [9:0]       idx_q, idx_d;
  logic             mrk_ok_q, mrk_ok_d;
  logic [2:0]       sts_q, sts_d;
  logic [7:0]       n_q, n_d;
  logic [15:0]      crc_rx_q, crc_rx_d;
  logic             pb_sticky_q, pb_sticky_d;
  logic [6:0]       rx_errs_q, rx_errs_d;
  logic             rx_errs_vld_q, rx_errs_vld_d;
  logic             service_req_q, service_req_d;
  logic             sd_busy_q, sd_busy_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       byte_take;
  logic [9:0] pay_end;
  logic [9:0] frame_len;
  logic       err_mrk, err_sts, err_n, err_pb, err_crc, err_ovf, ok;

  // Frame geometry and the error vector derived from the captured fields.
  always_comb begin
    byte_take = d_vld && (state_q != ST_REPORT);
    pay_end   = HDR_L + {2'b00, n_q};
    frame_len = pay_end + CRC_L;
    err_mrk   = ~mrk_ok_q;
    err_sts   = sts_q[0];
    err_n     = (idx_q != frame_len) || ({2'b00, n_q} > MAX_N);
    err_pb    = pb_sticky_q;
    err_crc   = (idx_q != frame_len) || (((crc_rx_q ^ crc_calc) & CRC_MASK) != 16'h0000);
    err_ovf   = (idx_q > frame_len);
    ok        = ~(err_mrk | err_sts | err_n | err_pb | err_crc | err_ovf);
    crc_en    = byte_take && (idx_q < pay_end);
    crc_rst   = (state_q == ST_REPORT);
  end

  // Next-state, field capture, report and statistics logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    mrk_ok_d      = mrk_ok_q;
    sts_d         = sts_q;
    n_d           = n_q;
    crc_rx_d      = crc_rx_q;
    pb_sticky_d   = pb_sticky_q;
    rx_errs_d     = rx_errs_q;
    rx_errs_vld_d = 1'b0;
    service_req_d = service_req_q;
    sd_busy_d     = sd_busy_q;
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;

    // A byte coinciding with frame_end is still processed before reporting.
    if (byte_take) begin
      idx_d = (idx_q == IDX_MAX) ? idx_q : idx_q + 10'd1;
      if (idx_q == MRK_IDX) mrk_ok_d = (d == MARKER);
      if (idx_q == STS_IDX) sts_d = d[2:0];
      if (idx_q == LEN_IDX) n_d = d;
      if ((idx_q >= pay_end) && (idx_q < frame_len)) crc_rx_d = {crc_rx_q[7:0], d};
    end

    if (pb_err && (state_q != ST_IDLE)) pb_sticky_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (frame_end)      state_d = ST_REPORT;
        else if (byte_take) state_d = ST_RX;
      end
      ST_RX: begin
        if (frame_end) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        state_d       = ST_IDLE;
        rx_errs_d     = {err_ovf, err_crc, err_pb, err_n, err_sts, err_mrk, ok};
        rx_errs_vld_d = 1'b1;
        service_req_d = sts_q[1];
        sd_busy_d     = sts_q[2];
        if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
        if (!ok && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
        // Leaving REPORT returns all per-frame captures to their idle values.
        idx_d       = 10'd0;
        mrk_ok_d    = 1'b0;
        sts_d       = 3'd0;
        n_d         = 8'd0;
        crc_rx_d    = 16'h0000;
        pb_sticky_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cnt_clr) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= 10'd0;
      mrk_ok_q      <= 1'b0;
      sts_q         <= 3'd0;
      n_q           <= 8'd0;
      crc_rx_q      <= 16'h0000;
      pb_sticky_q   <= 1'b0;
      rx_errs_q     <= 7'd0;
      rx_errs_vld_q <= 1'b0;
      service_req_q <= 1'b0;
      sd_busy_q     <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      mrk_ok_q      <= mrk_ok_d;
      sts_q         <= sts_d;
      n_q           <= n_d;
      crc_rx_q      <= crc_rx_d;
      pb_sticky_q   <= pb_sticky_d;
      rx_errs_q     <= rx_errs_d;
      rx_errs_vld_q <= rx_errs_vld_d;
      service_req_q <= service_req_d;
      sd_busy_q     <= sd_busy_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign rx_errs     = rx_errs_q;
  assign rx_errs_vld = rx_errs_vld_q;
  assign service_req = service_req_q;
  assign sd_busy     = sd_busy_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_m_rx_frame_check.sv
// Directed bench for m_rx_frame_check: hand-computed frames and expected reports.
// A second instance with 4-bit counters shares all inputs so that counter
// saturation is reachable in a short run.
module tb_m_rx_frame_check;

  logic        clk;
  logic        n_rst;
  logic [7:0]  d;
  logic        d_vld;
  logic        pb_err;
  logic [15:0] crc_calc;
  logic        frame_end;
  logic        cnt_clr;

  logic        crc_en, crc_rst, rx_errs_vld, service_req, sd_busy;
  logic [6:0]  rx_errs;
  logic [15:0] frame_cnt, err_cnt;

  logic        crc_en4, crc_rst4, rx_errs_vld4, service_req4, sd_busy4;
  logic [6:0]  rx_errs4;
  logic [3:0]  frame_cnt4, err_cnt4;

  int compared   = 0;
  int mismatched = 0;
  int en_cnt     = 0;
  logic [7:0] frm[$];

  m_rx_frame_check dut (
    .clk(clk), .n_rst(n_rst), .d(d), .d_vld(d_vld), .pb_err(pb_err),
    .crc_calc(crc_calc), .frame_end(frame_end), .cnt_clr(cnt_clr),
    .crc_en(crc_en), .crc_rst(crc_rst), .rx_errs(rx_errs),
    .rx_errs_vld(rx_errs_vld), .service_req(service_req), .sd_busy(sd_busy),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  m_rx_frame_check #(.CNT_W(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .d(d), .d_vld(d_vld), .pb_err(pb_err),
    .crc_calc(crc_calc), .frame_end(frame_end), .cnt_clr(cnt_clr),
    .crc_en(crc_en4), .crc_rst(crc_rst4), .rx_errs(rx_errs4),
    .rx_errs_vld(rx_errs_vld4), .service_req(service_req4), .sd_busy(sd_busy4),
    .frame_cnt(frame_cnt4), .err_cnt(err_cnt4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers: present one byte for one clock, tallying crc_en.
  task automatic send_byte(input logic [7:0] b, input bit pb, input bit fe);
    d = b; d_vld = 1'b1; pb_err = pb; frame_end = fe;
    #1;
    if (crc_en === 1'b1) en_cnt++;
    @(posedge clk); #1;
    d_vld = 1'b0; pb_err = 1'b0; frame_end = 1'b0;
  endtask

  // Sends frm; pb on byte pb_idx (-1 for none), frame_end on the last byte if fe_last.
  task automatic send_frm(input int pb_idx, input bit fe_last);
    en_cnt = 0;
    for (int i = 0; i < frm.size(); i++)
      send_byte(frm[i], (i == pb_idx), fe_last && (i == frm.size() - 1));
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rx_errs_vld === 1'b1) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_vld_seen"}, 32'(got), 32'd1);
  endtask

  // Called while the DUT sits in REPORT.
  task automatic expect_report(input string tag, input logic [6:0] errs, input bit sr,
                               input bit sb, input logic [15:0] fc, input logic [15:0] ec,
                               input int en);
    chk({tag, "_crc_rst"}, 32'(crc_rst), 32'd1);
    wait_vld(tag);
    chk({tag, "_errs"}, 32'(rx_errs), 32'(errs));
    chk({tag, "_service_req"}, 32'(service_req), 32'(sr));
    chk({tag, "_sd_busy"}, 32'(sd_busy), 32'(sb));
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(fc));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(ec));
    if (en >= 0) chk({tag, "_crc_en_bytes"}, 32'(en_cnt), 32'(en));
    @(posedge clk); #1;
    chk({tag, "_vld_one_cycle"}, 32'(rx_errs_vld), 32'd0);
    chk({tag, "_errs_hold"}, 32'(rx_errs), 32'(errs));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_crc_en"}, 32'(crc_en), 32'd0);
    chk({tag, "_crc_rst"}, 32'(crc_rst), 32'd0);
    chk({tag, "_errs"}, 32'(rx_errs), 32'd0);
    chk({tag, "_vld"}, 32'(rx_errs_vld), 32'd0);
    chk({tag, "_service_req"}, 32'(service_req), 32'd0);
    chk({tag, "_sd_busy"}, 32'(sd_busy), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    n_rst = 1'b0; d = 8'h00; d_vld = 1'b0; pb_err = 1'b0;
    crc_calc = 16'h1234; frame_end = 1'b0; cnt_clr = 1'b0;
    #23;
    chk_all_zero("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Good frame: N=2, status 06, CRC 12 34.
    frm = '{8'h5A, 8'h06, 8'h11, 8'h02, 8'hAA, 8'hBB, 8'h12, 8'h34};
    send_frm(-1, 1'b0); end_frame();
    expect_report("good", 7'b0000001, 1'b1, 1'b1, 16'd1, 16'd0, 6);

    // Bad marker and status bit 0.
    frm = '{8'h5B, 8'h01, 8'h11, 8'h02, 8'hAA, 8'hBB, 8'h12, 8'h34};
    send_frm(-1, 1'b0); end_frame();
    expect_report("mrk_sts", 7'b0000110, 1'b0, 1'b0, 16'd2, 16'd1, 6);

    // One payload byte too many.
    frm = '{8'h5A, 8'h06, 8'h11, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h12, 8'h34};
    send_frm(-1, 1'b0); end_frame();
    expect_report("overlong", 7'b1101000, 1'b1, 1'b1, 16'd3, 16'd2, 6);

    // Parity error on byte 4, then a clean frame to show the flag was cleared.
    frm = '{8'h5A, 8'h06, 8'h11, 8'h02, 8'hAA, 8'hBB, 8'h12, 8'h34};
    send_frm(4, 1'b0); end_frame();
    expect_report("pb", 7'b0010000, 1'b1, 1'b1, 16'd4, 16'd3, 6);
    send_frm(-1, 1'b0); end_frame();
    expect_report("pb_cleared", 7'b0000001, 1'b1, 1'b1, 16'd5, 16'd3, 6);

    // Empty frame.
    en_cnt = 0;
    end_frame();
    expect_report("empty", 7'b0101010, 1'b0, 1'b0, 16'd6, 16'd4, 0);

    // frame_end coincident with the last CRC byte.
    send_frm(-1, 1'b1);
    expect_report("coincident", 7'b0000001, 1'b1, 1'b1, 16'd7, 16'd4, 6);

    // Reset in the middle of the payload: nothing reported, everything zero.
    frm = '{8'h5A, 8'h06, 8'h11, 8'h02, 8'hAA};
    send_frm(-1, 1'b0);
    n_rst = 1'b0;
    #2;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    n_rst = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (rx_errs_vld !== 1'b0) seen = 1'b1;
        @(posedge clk); #1;
      end
      chk("midrst_no_report", 32'(seen), 32'd0);
      chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    end

    // Saturation: 20 empty (bad) frames; the 4-bit instance stops at F.
    for (int i = 0; i < 20; i++) begin
      end_frame();
      wait_vld("sat");
      @(posedge clk); #1;
    end
    chk("sat_frame_cnt16", 32'(frame_cnt), 32'd20);
    chk("sat_err_cnt16", 32'(err_cnt), 32'd20);
    chk("sat_frame_cnt4", 32'(frame_cnt4), 32'hF);
    chk("sat_err_cnt4", 32'(err_cnt4), 32'hF);

    // One more bad frame must leave the saturated counters unchanged.
    end_frame();
    wait_vld("sat_extra");
    chk("sat_extra_err_cnt4", 32'(err_cnt4), 32'hF);
    chk("sat_extra_err_cnt16", 32'(err_cnt), 32'd21);
    @(posedge clk); #1;

    // cnt_clr during REPORT wins over the increment.
    frm = '{8'h5A, 8'h06, 8'h11, 8'h02, 8'hAA, 8'hBB, 8'h12, 8'h34};
    send_frm(-1, 1'b0);
    end_frame();
    chk("clr_in_report", 32'(crc_rst), 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_vld", 32'(rx_errs_vld), 32'd1);
    chk("clr_errs", 32'(rx_errs), 32'd1);
    chk("clr_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    chk("clr_frame_cnt4", 32'(frame_cnt4), 32'd0);
    chk("clr_err_cnt4", 32'(err_cnt4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
